pmbist_resp_checker: RTL
========================

// Module: pmbist_resp_checker
// PURPOSE
// - Memory-side response checker downstream of pmbist_top; it drives pmbist_top's i_fail_flags and so_from_mem.
// - Aligns expected data/address from the microcode engine with memory read data. Compares on every compare strobe.
// - Keeps a sticky fail flag, a saturating fail count and the first-fail record.
// - The record is scanned out through the result chain, stitched between si_to_mem and so_from_mem.
// PARAMETERS
// - READ_LAT  1        cycles from i_comp_en to valid i_mem_rdata (1..4)
// - FCNT_W    4        fail counter width
// - ADDR_X/ADDR_Y/BG_DATA  from package pmbist (2/2/2)
// - RES_W     1+FCNT_W+ADDR_X+ADDR_Y+2*BG_DATA (13)   result chain length
// PORTS
// - clk          in   1        TCK-domain clock shared with pmbist_top
// - rst          in   1        synchronous, active-high reset
// - i_mbist_run  in   1        run indication (o_mbist_run)
// - i_comp_en    in   1        compare strobe issued with the read (o_comp_en)
// - i_addr_x     in   ADDR_X   read address X
// - i_addr_y     in   ADDR_Y   read address Y
// - i_exp_data   in   BG_DATA  expected background data (o_data)
// - i_mem_rdata  in   BG_DATA  memory read data, valid READ_LAT cycles after i_comp_en
// - i_shift_en   in   1        result shift enable (o_shift_result)
// - i_si         in   1        scan in (si_to_mem)
// - o_so         out  1        scan out = result[0] (so_from_mem)
// - o_fail_flag  out  1        sticky mismatch flag (to i_fail_flags bit)
// - o_done       out  1        results frozen, chain may be shifted
// BEHAVIOUR
// - Reset: state IDLE. Pipeline, count, record, result chain and all outputs are 0.
// - Delay line: {comp_en, addr_x, addr_y, exp_data} are delayed READ_LAT stages.
//   - The delayed comp_en is cmp_vld. The compare uses the delayed fields against i_mem_rdata.
//   - A mismatch counts only when cmp_vld=1.
// - FSM (run_q = i_mbist_run registered; rise = i_mbist_run & ~run_q):
//   - IDLE  -> RUN on rise.
//   - RUN   -> DRAIN when i_mbist_run=0. DRAIN loads the drain counter with READ_LAT.
//   - DRAIN -> DONE when the drain counter reaches 0. Compares continue in DRAIN so in-flight reads are checked.
//   - DONE  -> RUN on rise. Otherwise DONE holds.
//   - rise in any state: same cycle, flush the delay line and clear fail flag, count, record and chain. Clear wins over a compare in that cycle.
// - Mismatch at cycle t: o_fail_flag=1 from t+1, sticky until the next rise or rst.
//   - With READ_LAT=1, a strobe at cycle c is compared at c+1 and the flag shows at c+2.
// - Fail count: +1 per mismatch, saturates at 2**FCNT_W-1 with no wrap.
// - First-fail record: {act, exp, addr_y, addr_x} loads on the first mismatch only. Later mismatches do not change it.
// - Result chain: loads {act,exp,addr_y,addr_x,count,fail} on the cycle of the DRAIN->DONE transition.
//   - Layout [0]=fail, [FCNT_W:1]=count, then addr_x, addr_y, exp, act toward the MSB.
// - Shift: in IDLE or DONE with i_shift_en=1, chain <= {i_si, chain[RES_W-1:1]}.
//   - Shifting is destructive. i_shift_en is ignored in RUN/DRAIN.
// - o_so = chain[0] combinationally. o_done=1 only in DONE.
// - rst mid-RUN: everything returns to reset values at once. A pending delayed compare is discarded.
// - i_comp_en outside RUN/DRAIN enters the pipeline but is not counted.
// STRUCTURE
// - Package pmbist gains:
//   - t_chk_state enum {CHK_IDLE, CHK_RUN, CHK_DRAIN, CHK_DONE}
//   - localparams FCNT_W and RES_W
//   - READ_LAT_MAX = 4
// - Sub-module pmbist_delay_line #(W, DEPTH): sync-reset register pipe with a flush input. Used once for the aligned bundle.
// - The top of this file holds the FSM, the comparator, the counter, the record and the chain. Target ~200 lines.
// TESTING
// - Single fail: run, read x=2,y=1 exp=2'b01, rdata=2'b11, run low.
//   -> o_fail_flag=1 at c+2; o_done after drain; 13 shifts give 0x1AC3 LSB first.
// - Clean pass: 16 reads with matching data. -> o_fail_flag=0, count=0, chain shifts out 0x0000.
// - Saturation: 20 mismatching reads. -> count=15 with no wrap.
//   - The record holds the first failing address, not the last.
// - Restart: a second rise while in DONE. -> flag, count and chain are 0 in the next cycle.
//   - A compare strobe on the rise cycle is not counted.
// - Latency sweep, READ_LAT=3: mismatch on the last read right before run falls.
//   -> caught in DRAIN; o_done is 3 cycles after run falls; count=1.
// - Reset mid-run with a mismatch in flight: rst=1 for 1 cycle.
//   -> all outputs 0, state IDLE, and the in-flight compare is never counted.

Source files
------------

// File: rtl/pmbist_pkg.sv
// Shared types and sizes for the pmbist engine and its memory-side response checker.
// Pure declarations: no latency, no flow control.
package pmbist_pkg;

  localparam int ADDR_X       = 2;
  localparam int ADDR_Y       = 2;
  localparam int BG_DATA      = 2;
  localparam int FCNT_W       = 4;
  localparam int RES_W        = 1 + FCNT_W + ADDR_X + ADDR_Y + 2 * BG_DATA;
  localparam int READ_LAT_MAX = 4;
  localparam int DRAIN_W      = $clog2(READ_LAT_MAX + 1);

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_RUN,
    CHK_DRAIN,
    CHK_DONE
  } t_chk_state;

  // Read request as issued by the microcode engine, delayed to line up with read data
  typedef struct packed {
    logic               comp_en;
    logic [ADDR_X-1:0]  addr_x;
    logic [ADDR_Y-1:0]  addr_y;
    logic [BG_DATA-1:0] exp_data;
  } t_cmp_req;

  typedef struct packed {
    logic [BG_DATA-1:0] act_data;
    logic [BG_DATA-1:0] exp_data;
    logic [ADDR_Y-1:0]  addr_y;
    logic [ADDR_X-1:0]  addr_x;
  } t_fail_rec;

  // Result chain image; fail lands in bit 0 so it is the first bit scanned out
  typedef struct packed {
    t_fail_rec         rec;
    logic [FCNT_W-1:0] fcnt;
    logic              fail;
  } t_result;

endpackage

// File: rtl/pmbist_delay_line.sv
// Fixed-depth register pipe with synchronous clear; flush empties every stage at once.
// Latency DEPTH cycles; no backpressure, a new word enters every cycle.
module pmbist_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/pmbist_resp_checker.sv
// Aligns expected data with memory read data, tracks sticky fail/count/first-fail and scans the result out.
// Compare READ_LAT cycles after the strobe, flag one cycle later; no backpressure, shift only when idle/done.
module pmbist_resp_checker
  import pmbist_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mbist_run,
  input  logic               i_comp_en,
  input  logic [ADDR_X-1:0]  i_addr_x,
  input  logic [ADDR_Y-1:0]  i_addr_y,
  input  logic [BG_DATA-1:0] i_exp_data,
  input  logic [BG_DATA-1:0] i_mem_rdata,
  input  logic               i_shift_en,
  input  logic               i_si,
  output logic               o_so,
  output logic               o_fail_flag,
  output logic               o_done
);

  localparam int REQ_W = $bits(t_cmp_req);

  t_chk_state         state_q, state_d;
  logic               run_q;
  logic               rise;
  logic [DRAIN_W-1:0] drain_q;

  t_cmp_req           req_in, req_dly;
  logic [REQ_W-1:0]   req_dly_vec;

  logic               cmp_active, shift_ok, load_res;
  logic               mism;
  logic               fail_q, fail_d;
  logic [FCNT_W-1:0]  cnt_q, cnt_d;
  t_fail_rec          rec_q, rec_d;
  t_result            res_d;
  logic [RES_W-1:0]   chain_q;

  assign rise = i_mbist_run & ~run_q;

  assign req_in = '{comp_en: i_comp_en, addr_x: i_addr_x, addr_y: i_addr_y, exp_data: i_exp_data};

  pmbist_delay_line #(
    .W     (REQ_W),
    .DEPTH (READ_LAT)
  ) u_req_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (rise),
    .d     (req_in),
    .q     (req_dly_vec)
  );

  assign req_dly = t_cmp_req'(req_dly_vec);

  always_ff @(posedge clk) begin
    if (rst) state_q <= CHK_IDLE;
    else     state_q <= state_d;
  end

  // DRAIN lasts READ_LAT cycles so a strobe on the last RUN cycle is still compared
  always_comb begin
    state_d = state_q;
    case (state_q)
      CHK_IDLE:  if (rise)                      state_d = CHK_RUN;
      CHK_RUN:   if (!i_mbist_run)              state_d = CHK_DRAIN;
      CHK_DRAIN: if (drain_q <= DRAIN_W'(1))    state_d = CHK_DONE;
      CHK_DONE:  if (rise)                      state_d = CHK_RUN;
      default:                                  state_d = CHK_IDLE;
    endcase
  end

  always_comb begin
    cmp_active = (state_q == CHK_RUN) || (state_q == CHK_DRAIN);
    shift_ok   = i_shift_en && ((state_q == CHK_IDLE) || (state_q == CHK_DONE));
    load_res   = (state_q == CHK_DRAIN) && (state_d == CHK_DONE);
    o_done     = (state_q == CHK_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      drain_q <= '0;
    end else begin
      run_q <= i_mbist_run;
      if (state_q == CHK_RUN && state_d == CHK_DRAIN)
        drain_q <= DRAIN_W'(READ_LAT);
      else if (state_q == CHK_DRAIN && drain_q != '0)
        drain_q <= drain_q - DRAIN_W'(1);
    end
  end

  assign mism = req_dly.comp_en && cmp_active && (i_mem_rdata != req_dly.exp_data);

  // Next values feed the chain too, so a compare on the final DRAIN cycle is captured
  always_comb begin
    fail_d = fail_q | mism;
    cnt_d  = cnt_q;
    rec_d  = rec_q;
    if (mism && cnt_q != '1) cnt_d = cnt_q + FCNT_W'(1);
    if (mism && !fail_q)
      rec_d = '{act_data: i_mem_rdata, exp_data: req_dly.exp_data,
                addr_y: req_dly.addr_y, addr_x: req_dly.addr_x};
    res_d = '{rec: rec_d, fcnt: cnt_d, fail: fail_d};
  end

  always_ff @(posedge clk) begin
    if (rst || rise) begin
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      rec_q   <= '0;
      chain_q <= '0;
    end else begin
      fail_q <= fail_d;
      cnt_q  <= cnt_d;
      rec_q  <= rec_d;
      if (load_res)
        chain_q <= res_d;
      else if (shift_ok)
        chain_q <= {i_si, chain_q[RES_W-1:1]};
    end
  end

  assign o_so        = chain_q[0];
  assign o_fail_flag = fail_q;

endmodule
